// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_sequencer
//  Purpose  : Steps a 3-bit select code, which feeds a downstream 3-to-8
//             decoder, once every PRESCALE enabled clock cycles. The code
//             either wraps continuously or performs a single sweep that ends
//             with a done pulse. The count direction is sampled at every step.
//  Ports    : clk   - system clock; all state changes on its rising edge
//             rst   - synchronous, active-high reset
//             en    - count enable; 0 freezes the prescaler and sel
//             start - begin a sequence (accepted only while idle)
//             stop  - abort a running sequence
//             mode  - 0 = continuous wrap, 1 = single sweep (latched at start)
//             dir   - 0 = count up, 1 = count down
//             sel   - select code (registered)
//             step  - one-cycle pulse coincident with each new sel value
//             busy  - high while running
//             done  - one-cycle pulse at the end of a single sweep
//  Revision : 1.0  initial release
// ============================================================================
module scan_sequencer #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic       dir,
  output logic [2:0] sel,
  output logic       step,
  output logic       busy,
  output logic       done
);

  // Prescaler width; PRESCALE=1 still gets a 1-bit counter that stays at 0.
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    sel_q,   sel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mode_q,  mode_d;
  logic          step_q,  step_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic          at_terminal;

  // The terminal value depends on the current direction, since dir may
  // change mid-sweep.
  assign at_terminal = dir ? (sel_q == 3'b000) : (sel_q == 3'b111);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A simultaneous stop cancels the start.
        if (start && !stop) begin
          state_d = RUN;
          sel_d   = dir ? 3'b111 : 3'b000;
          presc_d = '0;
          mode_d  = mode;
        end
      end

      RUN: begin
        // stop wins over a coincident step event: sel is held and no pulse
        // is issued.
        if (stop) begin
          state_d = IDLE;
        end else if (en) begin
          if (presc_q == PMAX) begin
            presc_d = '0;
            if (mode_q && at_terminal) begin
              // End of the sweep: sel remains on the terminal value.
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              sel_d  = dir ? (sel_q - 3'd1) : (sel_q + 3'd1);
              step_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'b000;
      presc_q <= '0;
      mode_q  <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel  = sel_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_sequencer
//  Purpose  : Self-checking bench for scan_sequencer. The stimulus process
//             drives each cycle's inputs, advances a behavioural model and
//             queues the expected outputs; a monitor process pops the queue
//             after every rising edge and compares the result with the DUT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scan_sequencer;

  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       rst, en, start, stop, mode, dir;
  logic [2:0] sel;
  logic       step, busy, done;

  always #5 clk = ~clk;

  scan_sequencer #(.PRESCALE(PRESCALE)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .dir   (dir),
    .sel   (sel),
    .step  (step),
    .busy  (busy),
    .done  (done)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic       step;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model: whether a sequence is running, the select value, the
  // number of enabled cycles since the last step, and the latched mode.
  int   m_run  = 0;
  int   m_sel  = 0;
  int   m_cnt  = 0;
  int   m_mode = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the next rising
  // edge and queue what the DUT must present afterwards.
  task automatic cycle(input logic r, input logic e, input logic s,
                       input logic p, input logic m, input logic d);
    exp_t x;
    int   nxt;
    @(negedge clk);
    rst = r; en = e; start = s; stop = p; mode = m; dir = d;
    x.step = 1'b0;
    x.done = 1'b0;
    if (r) begin
      m_run = 0; m_sel = 0; m_cnt = 0;
    end else if (m_run == 0) begin
      if (s && !p) begin
        m_run  = 1;
        m_sel  = d ? 7 : 0;
        m_cnt  = 0;
        m_mode = int'(m);
      end
    end else if (p) begin
      m_run = 0;
    end else if (e) begin
      m_cnt++;
      if (m_cnt == PRESCALE) begin
        m_cnt = 0;
        nxt   = d ? m_sel - 1 : m_sel + 1;
        if (m_mode == 1 && (nxt < 0 || nxt > 7)) begin
          x.done = 1'b1;
          m_run  = 0;
        end else begin
          m_sel  = (nxt + 8) % 8;
          x.step = 1'b1;
        end
      end
    end
    x.sel  = 3'(m_sel);
    x.busy = (m_run != 0);
    exp_q.push_back(x);
  endtask

  // Monitor: compares every queued expectation one time unit after the edge.
  exp_t got;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check("sel",  int'(sel),  int'(got.sel));
      check("step", int'(step), int'(got.step));
      check("busy", int'(busy), int'(got.busy));
      check("done", int'(done), int'(got.done));
    end
  end

  int guard;

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0;

    // Reset after random activity.
    repeat (10) cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      1'($urandom), 1'($urandom));
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Continuous up sweep with a full wrap back to 000; start during RUN is ignored.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (36) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Single sweep down; done arrives 32 cycles after start.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (34) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Pause after two prescaler counts.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // stop coincident with a step event.
    guard = 0;
    while (m_cnt != PRESCALE - 1 && guard < 20) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // start together with stop while idle.
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a run.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (9) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Direction change once sel has reached 011.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (m_sel != 3 && guard < 40) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    repeat (3000) begin
      cycle(1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 9) < 8),
            1'($urandom_range(0, 9) < 3),
            1'($urandom_range(0, 49) == 0),
            1'($urandom),
            1'($urandom_range(0, 29) == 0) ^ dir);
    end

    // Let the monitor drain the queue.
    @(negedge clk);
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
